// File: rtl/mysoc_nios_oci_dct_capture_pkg.sv
// Shared types and sizing for the OCI DCT trace capture buffer.
// Optional feature macro: MYSOC_OCI_DCT_TIMESTAMP_EN (adds a 16-bit timestamp
// field in the MSBs of every stored entry).
package mysoc_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } dct_state_e;

  localparam int unsigned TS_WIDTH = 16;

  // Width of one stored entry: {[ts,] count, buffer}.
  function automatic int unsigned entry_w(input int unsigned dct_w,
                                          input int unsigned cnt_w);
`ifdef MYSOC_OCI_DCT_TIMESTAMP_EN
    return dct_w + cnt_w + TS_WIDTH;
`else
    return dct_w + cnt_w;
`endif
  endfunction

endpackage

// File: rtl/mysoc_nios_oci_dct_capture_if.sv
// Trace-in / read-out / status bundle of the DCT capture buffer.
// master = trace source and consumer side, slave = capture block.
interface mysoc_nios_oci_dct_capture_if #(
  parameter int unsigned DCT_WIDTH   = 30,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned DEPTH       = 16
);
  import mysoc_oci_dct_pkg::*;

  localparam int unsigned ENTRY_W = entry_w(DCT_WIDTH, COUNT_WIDTH);
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

  logic                   arm;
  logic                   dct_valid;
  logic [DCT_WIDTH-1:0]   dct_buffer;
  logic [COUNT_WIDTH-1:0] dct_count;
  logic                   test_ending;
  logic                   test_has_ended;
  logic                   rd_en;
  logic [ENTRY_W-1:0]     rd_data;
  logic                   rd_valid;
  logic [LEVEL_W-1:0]     level;
  logic                   overflow;
  logic [1:0]             state;
  logic                   done;

  modport master (
    output arm, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_en,
    input  rd_data, rd_valid, level, overflow, state, done
  );

  modport slave (
    input  arm, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_en,
    output rd_data, rd_valid, level, overflow, state, done
  );

endinterface

// File: rtl/mysoc_nios_oci_dct_capture_ring.sv
// Ring-buffer storage for DCT capture: memory, pointers, occupancy level and
// the full-buffer policy (overwrite oldest or drop newest).
module mysoc_oci_dct_ring #(
  parameter int unsigned ENTRY_W      = 34,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned STOP_ON_FULL = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [ENTRY_W-1:0]       wr_data_i,
  input  logic                     rd_en_i,
  output logic [ENTRY_W-1:0]       rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     lost_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [ENTRY_W-1:0] rd_data_q;
  logic               rd_valid_q;
  logic               full, empty;
  logic               do_rd, do_wr, do_ovw, lost;

  // Decide read/write/overwrite for this cycle and the next pointer/level values.
  always_comb begin
    full    = (level_q == FULL_LVL);
    empty   = (level_q == '0);
    do_rd   = rd_en_i && !empty && !clr_i;
    do_wr   = 1'b0;
    do_ovw  = 1'b0;
    lost    = 1'b0;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_en_i && !clr_i) begin
      if (!full || do_rd) begin
        do_wr = 1'b1;
      end else if (STOP_ON_FULL == 0) begin
        do_wr  = 1'b1;
        do_ovw = 1'b1;
        lost   = 1'b1;
      end else begin
        lost = 1'b1;
      end
    end
    if (do_wr) wptr_d = wptr_q + PTR_W'(1);
    // An overwrite retires the oldest entry, so the read pointer follows.
    if (do_rd || do_ovw) rptr_d = rptr_q + PTR_W'(1);
    case ({do_wr && !do_ovw, do_rd})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  // Pointer, level and registered read-port state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_valid_q <= do_rd;
      if (do_rd) rd_data_q <= mem_q[rptr_q];
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign level_o    = level_q;
  assign lost_o     = lost;

endmodule

// File: rtl/mysoc_nios_oci_dct_capture.sv
// Nios II OCI debug-trace (DCT) capture buffer: session FSM, sticky overflow
// and optional timestamp around a ring-buffer store.
// Optional feature macro: MYSOC_OCI_DCT_TIMESTAMP_EN.
module mysoc_nios_oci_dct_capture
  import mysoc_oci_dct_pkg::*;
#(
  parameter int unsigned DCT_WIDTH    = 30,
  parameter int unsigned COUNT_WIDTH  = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned STOP_ON_FULL = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  mysoc_nios_oci_dct_capture_if.slave  bus
);
  localparam int unsigned ENTRY_W = entry_w(DCT_WIDTH, COUNT_WIDTH);
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;

  dct_state_e         state_q;
  logic               done_q;
  logic               overflow_q;
  logic               arm_ok;
  logic               clr;
  logic               wr_en;
  logic               lost;
  logic [LVL_W-1:0]   level;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;

  assign arm_ok = bus.arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign clr    = bus.arm && (state_q == ST_DONE);
  assign wr_en  = bus.dct_valid && (state_q == ST_CAPTURE);

`ifdef MYSOC_OCI_DCT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Session-relative timestamp: restarts on an accepted arm, runs in CAPTURE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else if (arm_ok) begin
      ts_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  assign wr_data = {ts_q, bus.dct_count, bus.dct_buffer};
`else
  assign wr_data = {bus.dct_count, bus.dct_buffer};
`endif

  // Session FSM with registered done and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (lost) overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (arm_ok) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (bus.test_ending || bus.test_has_ended) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((level == '0) && bus.test_has_ended) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (arm_ok) begin
            state_q    <= ST_CAPTURE;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
      endcase
    end
  end

  mysoc_oci_dct_ring #(
    .ENTRY_W      (ENTRY_W),
    .DEPTH        (DEPTH),
    .STOP_ON_FULL (STOP_ON_FULL)
  ) u_ring (
    .clk_i      (clk),
    .rst_n_i    (reset_n),
    .clr_i      (clr),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (bus.rd_en),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .level_o    (level),
    .lost_o     (lost)
  );

  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.level    = level;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mysoc_nios_oci_dct_capture.sv
// Bench for mysoc_nios_oci_dct_capture: two DEPTH=4 instances (overwrite and
// drop policy) driven with identical stimulus.
module tb_mysoc_nios_oci_dct_capture;
  import mysoc_oci_dct_pkg::*;

  localparam int DW = 30;
  localparam int CW = 4;
  localparam int DP = 4;
  localparam int EW = entry_w(DW, CW);

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic arm = 1'b0, dct_valid = 1'b0, test_ending = 1'b0, test_has_ended = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] dct_data = '0;
  logic [CW-1:0] dct_cnt = '0;

  int checks = 0;
  int errors = 0;
  bit chk_model = 1'b0;

  always #5 clk = ~clk;

  mysoc_nios_oci_dct_capture_if #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DP)) ifa ();
  mysoc_nios_oci_dct_capture_if #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DP)) ifb ();

  assign ifa.arm = arm;              assign ifb.arm = arm;
  assign ifa.dct_valid = dct_valid;  assign ifb.dct_valid = dct_valid;
  assign ifa.dct_buffer = dct_data;  assign ifb.dct_buffer = dct_data;
  assign ifa.dct_count = dct_cnt;    assign ifb.dct_count = dct_cnt;
  assign ifa.test_ending = test_ending;       assign ifb.test_ending = test_ending;
  assign ifa.test_has_ended = test_has_ended; assign ifb.test_has_ended = test_has_ended;
  assign ifa.rd_en = rd_en;          assign ifb.rd_en = rd_en;

  mysoc_nios_oci_dct_capture #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DP), .STOP_ON_FULL(0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  mysoc_nios_oci_dct_capture #(.DCT_WIDTH(DW), .COUNT_WIDTH(CW), .DEPTH(DP), .STOP_ON_FULL(1))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  // Reference model: per instance, a queue of stored words plus session state.
  logic [63:0] mq [2][$];
  int          mst [2];
  bit          movf [2];
  bit          mrv [2];
  logic [63:0] mrd [2];
  int          mts [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mst[m] = 0; movf[m] = 0; mrv[m] = 0; mrd[m] = '0; mts[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int pre;
      bit rd_ok, wr_ok;
      logic [63:0] ent;
      pre   = mq[m].size();
      rd_ok = rd_en && (pre > 0) && !(arm && mst[m] == 3);
      wr_ok = dct_valid && (mst[m] == 1);
      ent   = 64'(dct_data) | (64'(dct_cnt) << DW);
`ifdef MYSOC_OCI_DCT_TIMESTAMP_EN
      ent   = ent | (64'(mts[m]) << (DW + CW));
`endif
      mrv[m] = rd_ok;
      if (rd_ok) mrd[m] = mq[m].pop_front();
      if (wr_ok) begin
        if (mq[m].size() < DP) mq[m].push_back(ent);
        else begin
          movf[m] = 1;
          if (m == 0) begin
            void'(mq[m].pop_front());
            mq[m].push_back(ent);
          end
        end
      end
      if (mst[m] == 1) mts[m] = (mts[m] + 1) % 65536;
      case (mst[m])
        0: if (arm) begin mst[m] = 1; mts[m] = 0; end
        1: if (test_ending || test_has_ended) mst[m] = 2;
        2: if (pre == 0 && test_has_ended) mst[m] = 3;
        3: if (arm) begin mst[m] = 1; movf[m] = 0; mq[m].delete(); mts[m] = 0; end
        default: mst[m] = 0;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic grab(input int m, output logic [63:0] lvl, output logic [63:0] ovf,
                      output logic [63:0] rv, output logic [63:0] rd,
                      output logic [63:0] st, output logic [63:0] dn);
    if (m == 0) begin
      lvl = 64'(ifa.level); ovf = 64'(ifa.overflow); rv = 64'(ifa.rd_valid);
      rd = 64'(ifa.rd_data); st = 64'(ifa.state); dn = 64'(ifa.done);
    end else begin
      lvl = 64'(ifb.level); ovf = 64'(ifb.overflow); rv = 64'(ifb.rd_valid);
      rd = 64'(ifb.rd_data); st = 64'(ifb.state); dn = 64'(ifb.done);
    end
  endtask

  task automatic check_model();
    logic [63:0] lvl, ovf, rv, rd, st, dn;
    for (int m = 0; m < 2; m++) begin
      grab(m, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("rnd_level%0d", m), lvl, 64'(mq[m].size()));
      chk($sformatf("rnd_ovf%0d", m), ovf, 64'(movf[m]));
      chk($sformatf("rnd_rv%0d", m), rv, 64'(mrv[m]));
      chk($sformatf("rnd_rdata%0d", m), rd, mrd[m]);
      chk($sformatf("rnd_state%0d", m), st, 64'(mst[m]));
      chk($sformatf("rnd_done%0d", m), dn, 64'(mst[m] == 3));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (chk_model) check_model();
  endtask

  task automatic idle_inputs();
    arm = 0; dct_valid = 0; test_ending = 0; test_has_ended = 0; rd_en = 0;
    dct_data = '0; dct_cnt = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic write_word(input int v);
    dct_valid = 1; dct_data = DW'(v); dct_cnt = '0;
    step();
    dct_valid = 0;
  endtask

  // Both instances share these expectations (values chosen never to fill the buffer).
  typedef struct {
    logic          arm, vld;
    logic [DW-1:0] dat;
    logic [CW-1:0] cnt;
    logic          te, the, rd;
    int            lvl;
    logic          rv;
    logic [DW-1:0] rdat;
    logic [CW-1:0] rcnt;
    int            st;
    logic          ovf, dn;
  } vec_t;

  vec_t tv [14];

  initial begin
    logic [63:0] lvl, ovf, rv, rd, st, dn;

    tv[0]  = '{1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 30'h0, 4'h0, 1, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 30'h1, 4'h4, 1'b0, 1'b0, 1'b0, 1, 1'b0, 30'h0, 4'h0, 1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 30'h2, 4'h4, 1'b0, 1'b0, 1'b0, 2, 1'b0, 30'h0, 4'h0, 1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 30'h3, 4'h4, 1'b1, 1'b0, 1'b0, 3, 1'b0, 30'h0, 4'h0, 2, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 30'h1, 4'h4, 2, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 30'h2, 4'h4, 2, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 30'h3, 4'h4, 2, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 30'h3, 4'h4, 3, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 30'h3, 4'h4, 3, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 30'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 30'h3, 4'h4, 1, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b1, 30'h2AAAAAAA, 4'hF, 1'b0, 1'b0, 1'b0, 1, 1'b0, 30'h3, 4'h4, 1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 30'h3, 4'h4, 2, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 30'h2AAAAAAA, 4'hF, 2, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 30'h2AAAAAAA, 4'hF, 3, 1'b0, 1'b1};

    #1;
    do_reset();
    reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      grab(m, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("rst_level%0d", m), lvl, 0);
      chk($sformatf("rst_ovf%0d", m), ovf, 0);
      chk($sformatf("rst_rv%0d", m), rv, 0);
      chk($sformatf("rst_rdata%0d", m), rd, 0);
      chk($sformatf("rst_state%0d", m), st, 0);
      chk($sformatf("rst_done%0d", m), dn, 0);
    end
    do_reset();

    // Basic session from the table.
    for (int i = 0; i < 14; i++) begin
      arm = tv[i].arm; dct_valid = tv[i].vld; dct_data = tv[i].dat; dct_cnt = tv[i].cnt;
      test_ending = tv[i].te; test_has_ended = tv[i].the; rd_en = tv[i].rd;
      step();
      for (int m = 0; m < 2; m++) begin
        grab(m, lvl, ovf, rv, rd, st, dn);
        chk($sformatf("tbl%0d_level%0d", i, m), lvl, 64'(tv[i].lvl));
        chk($sformatf("tbl%0d_rv%0d", i, m), rv, 64'(tv[i].rv));
        chk($sformatf("tbl%0d_rdata%0d", i, m), 64'(rd[DW+CW-1:0]), 64'({tv[i].rcnt, tv[i].rdat}));
        chk($sformatf("tbl%0d_state%0d", i, m), st, 64'(tv[i].st));
        chk($sformatf("tbl%0d_ovf%0d", i, m), ovf, 64'(tv[i].ovf));
        chk($sformatf("tbl%0d_done%0d", i, m), dn, 64'(tv[i].dn));
      end
    end
    idle_inputs();

    // Full buffer: A overwrites oldest, B drops newest.
    do_reset();
    arm = 1; step(); arm = 0;
    for (int v = 0; v < 6; v++) write_word(v);
    for (int m = 0; m < 2; m++) begin
      grab(m, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("full_level%0d", m), lvl, 4);
      chk($sformatf("full_ovf%0d", m), ovf, 1);
    end
    test_ending = 1; step(); test_ending = 0;
    for (int k = 0; k < 4; k++) begin
      rd_en = 1; step();
      grab(0, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("ovw_pop%0d", k), 64'(rd[DW-1:0]), 64'(k + 2));
      chk($sformatf("ovw_rv%0d", k), rv, 1);
      grab(1, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("drop_pop%0d", k), 64'(rd[DW-1:0]), 64'(k));
    end
    rd_en = 0;

    // Simultaneous read and write on full, then on empty.
    do_reset();
    arm = 1; step(); arm = 0;
    for (int v = 10; v < 14; v++) write_word(v);
    dct_valid = 1; dct_data = 30'd14; rd_en = 1; step();
    dct_valid = 0; rd_en = 0;
    for (int m = 0; m < 2; m++) begin
      grab(m, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("fullrw_level%0d", m), lvl, 4);
      chk($sformatf("fullrw_ovf%0d", m), ovf, 0);
      chk($sformatf("fullrw_rdata%0d", m), 64'(rd[DW-1:0]), 10);
    end
    do_reset();
    arm = 1; step(); arm = 0;
    dct_valid = 1; dct_data = 30'd7; rd_en = 1; step();
    dct_valid = 0; rd_en = 0;
    for (int m = 0; m < 2; m++) begin
      grab(m, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("emptyrw_level%0d", m), lvl, 1);
      chk($sformatf("emptyrw_rv%0d", m), rv, 0);
    end

    // Asynchronous reset with level 3, overflow and rd_valid all set.
    do_reset();
    arm = 1; step(); arm = 0;
    for (int v = 0; v < 5; v++) write_word(v);
    rd_en = 1; step(); rd_en = 0;
    grab(0, lvl, ovf, rv, rd, st, dn);
    chk("pre_rst_level", lvl, 3);
    chk("pre_rst_ovf", ovf, 1);
    chk("pre_rst_rv", rv, 1);
    reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      grab(m, lvl, ovf, rv, rd, st, dn);
      chk($sformatf("midrst_level%0d", m), lvl, 0);
      chk($sformatf("midrst_ovf%0d", m), ovf, 0);
      chk($sformatf("midrst_rv%0d", m), rv, 0);
      chk($sformatf("midrst_done%0d", m), dn, 0);
      chk($sformatf("midrst_state%0d", m), st, 0);
    end

`ifdef MYSOC_OCI_DCT_TIMESTAMP_EN
    do_reset();
    arm = 1; step(); arm = 0;
    repeat (5) step();
    write_word(7);
    test_ending = 1; step(); test_ending = 0;
    rd_en = 1; step(); rd_en = 0;
    grab(0, lvl, ovf, rv, rd, st, dn);
    chk("ts_first", 64'(rd[EW-1 -: 16]), 5);
    test_has_ended = 1; step(); test_has_ended = 0;
    grab(0, lvl, ovf, rv, rd, st, dn);
    chk("ts_done", st, 3);
    arm = 1; step(); arm = 0;
    write_word(8);
    test_ending = 1; step(); test_ending = 0;
    rd_en = 1; step(); rd_en = 0;
    grab(0, lvl, ovf, rv, rd, st, dn);
    chk("ts_rearm", 64'(rd[EW-1 -: 16]), 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    chk_model = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      int blk;
      blk = c / 100;
      arm            = ($urandom_range(0, 19) == 0);
      dct_valid      = ($urandom_range(0, 1) == 1);
      dct_data       = DW'($urandom);
      dct_cnt        = CW'($urandom);
      test_ending    = ($urandom_range(0, 29) == 0);
      test_has_ended = ($urandom_range(0, 3) == 0);
      rd_en          = ($urandom_range(0, 99) < ((blk % 2 == 1) ? 60 : 15));
      step();
    end
    chk_model = 1'b0;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mysoc_nios_oci_dct_capture.md
# mysoc_nios_oci_dct_capture

Parametrised, synthesizable capture buffer for the Nios II OCI debug trace (DCT) stream in MySoc, succeeding the current input-only OCI test-bench stub. It stores each qualified `{dct_count, dct_buffer}` word in a ring buffer, sequences capture and drain around the `test_ending` and `test_has_ended` events, and exposes a pull-style read port plus status for a host-side or bench-side consumer.

## Interface
- `DCT_WIDTH`, 30: width of `dct_buffer`.
- `COUNT_WIDTH`, 4: width of `dct_count`.
- `DEPTH`, 16: buffer entries; power of two, at least 2.
- `STOP_ON_FULL`, 0: 0 overwrites the oldest entry when full; 1 drops the new word.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `arm` in 1: one-cycle pulse that starts a capture session.
- `dct_valid` in 1: qualifies `dct_buffer` and `dct_count` this cycle.
- `dct_buffer` in DCT_WIDTH: trace data.
- `dct_count` in COUNT_WIDTH: trace word count tag.
- `test_ending` in 1: stops capture.
- `test_has_ended` in 1: level signal; allows completion once the buffer is drained.
- `rd_en` in 1: pop request.
- `rd_data` out ENTRY_W: popped entry. ENTRY_W = COUNT_WIDTH + DCT_WIDTH, plus TS_WIDTH when the timestamp feature is compiled in. Packing is `{[ts,] count, buffer}` with `buffer` in the LSBs.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `level` out clog2(DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky flag; at least one word was lost or overwritten.
- `state` out 2: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
- `done` out 1: high while in DONE.

## Operation
- **Reset:** state is IDLE. Pointers, `level`, `overflow`, `rd_valid`, and `done` are 0. `rd_data` is 0.
- **IDLE:**
  - `arm` moves the block to CAPTURE.
  - Writes are ignored.
  - Reads are allowed.
- **CAPTURE:**
  - `dct_valid` writes one entry.
  - `test_ending` or `test_has_ended` moves the block to DRAIN.
  - A write in the same cycle as `test_ending` is still taken.
- **DRAIN:**
  - No writes are accepted.
  - When `level`==0 and `test_has_ended`=1, the block moves to DONE.
- **DONE:**
  - `arm` clears the pointers and `overflow`, then moves the block to CAPTURE.
  - `arm` is ignored in CAPTURE and DRAIN.
- **Full buffer, STOP_ON_FULL=0:** a write overwrites the oldest entry. The read pointer advances, `level` stays at DEPTH, and `overflow` is set.
- **Full buffer, STOP_ON_FULL=1:** the write is dropped and `overflow` is set.
- **Full buffer with a simultaneous read and write:** both proceed, `level` is unchanged, and `overflow` is not set.
- **Empty buffer with a simultaneous read and write:** the read is ignored and `level` becomes 1. There is no fall-through.
- **`rd_en` while empty:** ignored; `rd_valid` is 0 in the next cycle.
- **Pointers:** log2(DEPTH) bits wide; they wrap naturally.

## Timing
- **Write:** committed on the edge where `dct_valid` is sampled high. `level` reflects it one cycle later.
- **Read:** `rd_en` at edge N gives `rd_valid`=1 and `rd_data` during cycle N+1.
- `rd_valid` stays high for exactly one cycle per pop.
- Back-to-back `rd_en` gives one entry per cycle.
- **State transitions:** registered, with one cycle of latency from the trigger input.
- `done` is asserted in the same cycle that `state` shows DONE.
- **Reset mid-operation:** all contents are discarded immediately and asynchronously. Deassertion is synchronised externally.

## Configuration
- **Macro:** `MYSOC_OCI_DCT_TIMESTAMP_EN`.
- **When defined:**
  - A free-running TS_WIDTH=16 counter is cleared by reset and by `arm`.
  - It increments every cycle in CAPTURE and wraps at 2^16.
  - Its value is stored as the MSBs of each written entry.
- **When undefined:**
  - There is no counter.
  - ENTRY_W = COUNT_WIDTH + DCT_WIDTH.

## Structure
- **Package `mysoc_oci_dct_pkg`** holds:
  - the state enum: IDLE, CAPTURE, DRAIN, DONE;
  - TS_WIDTH;
  - an entry-width function.
- **Sub-module `mysoc_oci_dct_ring`** holds the storage: DEPTH×ENTRY_W memory, pointers, level, full/empty, and overwrite/drop logic.
- **Top level** holds the state machine, the timestamp counter, and the `overflow` register.

## Test plan
- **Basic write/read:** reset, then `arm`; write 3 words (0x1, 0x2, 0x3 with count 4); raise `test_ending`, then pop 3 times. Required: `rd_data` low bits are 0x1, 0x2, 0x3; `level` is 0; with `test_has_ended` high the block reaches DONE one cycle after the buffer empties.
- **Overwrite on full:** STOP_ON_FULL=0, DEPTH=4; write 6 words 0..5. Required: `level` is 4, `overflow` is 1, and the pops return 2, 3, 4, 5.
- **Drop on full:** STOP_ON_FULL=1, DEPTH=4; write 6 words 0..5. Required: `overflow` is 1 and the pops return 0, 1, 2, 3.
- **Simultaneous read/write:** full buffer, then read and write in the same cycle. Required: `level` stays 4 and `overflow` stays 0. Empty buffer, then read and write in the same cycle. Required: `level` is 1 and `rd_valid` is 0.
- **Reset mid-capture:** pull `reset_n` low while `level` is 3. Required: `level`, `overflow`, `rd_valid`, and `done` are all 0 immediately, and the state is IDLE.
- **Timestamp feature:** with `MYSOC_OCI_DCT_TIMESTAMP_EN` defined, `arm`, idle for 5 cycles, then write. Required: the entry's timestamp field is 5; `arm` from DONE resets the timestamp to 0.
